// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding, default widths and width helpers for the APB request arbiter
package apb_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: requester, command and observed-bus signals of the APB request arbiter
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_rw;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic rsp_err;
  logic transfer;
  logic read_write;
  logic [ADDR_WIDTH-1:0] apb_write_paddr;
  logic [ADDR_WIDTH-1:0] apb_read_paddr;
  logic [DATA_WIDTH-1:0] apb_write_data;
  logic [DATA_WIDTH-1:0] apb_read_data_out;
  logic pslverr;
  logic psel;
  logic penable;
  logic pready;
  modport master (
    output req_valid, req_rw, req_addr, req_wdata, apb_read_data_out, pslverr, psel, penable, pready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, transfer, read_write, apb_write_paddr,
    apb_read_paddr, apb_write_data
  );
  modport slave (
    input req_valid, req_rw, req_addr, req_wdata, apb_read_data_out, pslverr, psel, penable, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, transfer, read_write, apb_write_paddr,
    apb_read_paddr, apb_write_data
  );
endinterface

// File: rtl/apb_rr_picker.sv
// apb_rr_picker: round-robin winner search starting just after the last granted requester
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  // Scan offsets from farthest to nearest so the nearest valid requester after last_i wins
  always_comb begin
    idx_o = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % NUM_REQ]) idx_o = IW'((int'(last_i) + k) % NUM_REQ);
    end
    any_o = |req_i;
    grant_o = any_o ? NUM_REQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB controller command port among NUM_REQ requesters
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic pclk,
  input logic presetn,
  apb_req_arbiter_if.slave bus
);
  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = cnt_width(TIMEOUT);
  state_e state_q;
  logic [IW-1:0] last_q, owner_q, idx;
  logic [NUM_REQ-1:0] grant, req_ready_q, rsp_valid_q;
  logic any, done, rw_q, rsp_err_q, transfer_q, read_write_q;
  logic [ADDR_WIDTH-1:0] addr_q, wpaddr_q, rpaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, apb_wdata_q, rsp_rdata_q;
  logic [CW-1:0] cnt_q;
  assign done = bus.psel & bus.penable & bus.pready;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.transfer = transfer_q;
  assign bus.read_write = read_write_q;
  assign bus.apb_write_paddr = wpaddr_q;
  assign bus.apb_read_paddr = rpaddr_q;
  assign bus.apb_write_data = apb_wdata_q;
  apb_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .grant_o(grant),
    .idx_o  (idx),
    .any_o  (any)
  );
  // Transaction FSM: grant in IDLE, strobe the command, wait for completion or timeout, answer the owner
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
      transfer_q <= 1'b0;
      read_write_q <= 1'b0;
      wpaddr_q <= '0;
      rpaddr_q <= '0;
      apb_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (any) begin
          req_ready_q <= grant;
          owner_q <= idx;
          rw_q <= bus.req_rw[idx];
          addr_q <= bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q <= bus.req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
          state_q <= ISSUE;
        end
        ISSUE: begin
          req_ready_q <= '0;
          transfer_q <= 1'b1;
          read_write_q <= rw_q;
          wpaddr_q <= rw_q ? '0 : addr_q;
          apb_wdata_q <= rw_q ? '0 : wdata_q;
          rpaddr_q <= rw_q ? addr_q : '0;
          cnt_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          transfer_q <= 1'b0;
          cnt_q <= cnt_q + CW'(1);
          if (done || cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_valid_q <= NUM_REQ'(1) << owner_q;
            rsp_rdata_q <= (done && rw_q) ? bus.apb_read_data_out : '0;
            rsp_err_q <= done ? bus.pslverr : 1'b1;
            read_write_q <= 1'b0;
            wpaddr_q <= '0;
            rpaddr_q <= '0;
            apb_wdata_q <= '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
          rsp_err_q <= 1'b0;
          last_q <= owner_q;
          cnt_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed scenario tasks checking grant, command, completion, error, timeout and reset behaviour
module tb_apb_req_arbiter;
  logic pclk = 1'b0;
  logic presetn = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  apb_req_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(9), .DATA_WIDTH(8)) bus ();
  apb_req_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(9), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );
  always #5 pclk = ~pclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [44:0] all_out();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.transfer, bus.read_write,
            bus.apb_write_paddr, bus.apb_read_paddr, bus.apb_write_data};
  endfunction
  task automatic set_req(input int i, input logic rw, input logic [8:0] a, input logic [7:0] d);
    bus.req_rw[i] = rw;
    bus.req_addr[i*9 +: 9] = a;
    bus.req_wdata[i*8 +: 8] = d;
    bus.req_valid[i] = 1'b1;
  endtask
  task automatic bus_idle();
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    bus.pready = 1'b0;
    bus.pslverr = 1'b0;
    bus.apb_read_data_out = '0;
  endtask
  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_rw = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus_idle();
    #1 presetn = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out()); end
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h expected 0", all_out()); end
  endtask
  task automatic test_write();
    @(negedge pclk);
    set_req(0, 1'b0, 9'h12A, 8'h5C);
    @(negedge pclk);
    n_checks++;
    if (bus.req_ready !== 4'b0001 || bus.transfer !== 1'b0) begin n_fail++; $display("FAIL wr_ready: got ready=%b transfer=%b expected ready=0001 transfer=0", bus.req_ready, bus.transfer); end
    bus.req_valid = '0;
    @(negedge pclk);
    n_checks++;
    if (bus.transfer !== 1'b1 || bus.read_write !== 1'b0 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL wr_transfer: got transfer=%b rw=%b ready=%b expected 1 0 0000", bus.transfer, bus.read_write, bus.req_ready); end
    n_checks++;
    if ({bus.apb_write_paddr, bus.apb_write_data, bus.apb_read_paddr} !== {9'h12A, 8'h5C, 9'h000}) begin n_fail++; $display("FAIL wr_command: got waddr=%h wdata=%h raddr=%h expected 12a 5c 000", bus.apb_write_paddr, bus.apb_write_data, bus.apb_read_paddr); end
    bus.psel = 1'b1;
    bus.penable = 1'b1;
    bus.pready = 1'b1;
    @(negedge pclk);
    bus_idle();
    n_checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b0 || bus.transfer !== 1'b0) begin n_fail++; $display("FAIL wr_rsp: got rsp_valid=%b err=%b transfer=%b expected 0001 0 0", bus.rsp_valid, bus.rsp_err, bus.transfer); end
    @(negedge pclk);
    n_checks++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL wr_back_idle: got %h expected 0", all_out()); end
  endtask
  task automatic test_read();
    @(negedge pclk);
    set_req(2, 1'b1, 9'h045, 8'h00);
    @(negedge pclk);
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rd_ready: got %b expected 0100", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge pclk);
    n_checks++;
    if ({bus.transfer, bus.read_write, bus.apb_read_paddr, bus.apb_write_paddr} !== {1'b1, 1'b1, 9'h045, 9'h000}) begin n_fail++; $display("FAIL rd_command: got transfer=%b rw=%b raddr=%h waddr=%h expected 1 1 045 000", bus.transfer, bus.read_write, bus.apb_read_paddr, bus.apb_write_paddr); end
    @(negedge pclk);
    n_checks++;
    if ({bus.transfer, bus.read_write, bus.apb_read_paddr} !== {1'b0, 1'b1, 9'h045}) begin n_fail++; $display("FAIL rd_hold: got transfer=%b rw=%b raddr=%h expected 0 1 045", bus.transfer, bus.read_write, bus.apb_read_paddr); end
    bus.psel = 1'b1;
    bus.penable = 1'b1;
    bus.pready = 1'b1;
    bus.apb_read_data_out = 8'hA7;
    @(negedge pclk);
    bus_idle();
    n_checks++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 8'hA7 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got rsp_valid=%b rdata=%h err=%b expected 0100 a7 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
    @(negedge pclk);
    n_checks++;
    if (bus.rsp_rdata !== 8'h00 || bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rd_rdata_clear: got rdata=%h rsp_valid=%b expected 00 0000", bus.rsp_rdata, bus.rsp_valid); end
  endtask
  task automatic test_fairness();
    int got[$];
    int at[$];
    int cyc = 0;
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 9'h100 + 9'(i), 8'h10 + 8'(i));
    bus.psel = 1'b1;
    bus.penable = 1'b1;
    bus.pready = 1'b1;
    while (got.size() < 6 && cyc < 60) begin
      @(negedge pclk);
      cyc++;
      for (int j = 0; j < 4; j++) if (bus.req_ready[j]) begin got.push_back(j); at.push_back(cyc); end
    end
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (k >= got.size() || got[k] != k % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, (k < got.size()) ? got[k] : -1, k % 4); end
    end
    n_checks++;
    if (got.size() != 6 || at[5] - at[0] != 20) begin n_fail++; $display("FAIL rr_spacing: got %0d grants spanning %0d cycles expected 6 spanning 20", got.size(), (got.size() == 6) ? at[5] - at[0] : -1); end
    repeat (4) @(negedge pclk);
    bus_idle();
  endtask
  task automatic test_slave_error();
    @(negedge pclk);
    set_req(1, 1'b0, 9'h0AB, 8'h33);
    @(negedge pclk);
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL err_ready: got %b expected 0010", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge pclk);
    bus.psel = 1'b1;
    bus.penable = 1'b1;
    bus.pready = 1'b1;
    bus.pslverr = 1'b1;
    bus.apb_read_data_out = 8'hFF;
    @(negedge pclk);
    bus_idle();
    n_checks++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL err_rsp: got rsp_valid=%b err=%b rdata=%h expected 0010 1 00", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    @(negedge pclk);
  endtask
  task automatic test_timeout();
    int k = 0;
    @(negedge pclk);
    set_req(0, 1'b1, 9'h1FF, 8'h00);
    bus.psel = 1'b1;
    bus.penable = 1'b1;
    bus.apb_read_data_out = 8'h77;
    @(negedge pclk);
    bus.req_valid = '0;
    @(negedge pclk);
    n_checks++;
    if (bus.transfer !== 1'b1) begin n_fail++; $display("FAIL to_transfer: got %b expected 1", bus.transfer); end
    while (bus.rsp_valid === 4'b0000 && k < 40) begin
      @(negedge pclk);
      k++;
    end
    n_checks++;
    if (k != 15) begin n_fail++; $display("FAIL to_wait_cycles: got %0d expected 15", k); end
    n_checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL to_rsp: got rsp_valid=%b err=%b rdata=%h expected 0001 1 00", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    bus_idle();
    @(negedge pclk);
    n_checks++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL to_back_idle: got %h expected 0", all_out()); end
  endtask
  task automatic test_timeout_edge();
    @(negedge pclk);
    set_req(0, 1'b1, 9'h0C3, 8'h00);
    bus.psel = 1'b1;
    bus.penable = 1'b1;
    @(negedge pclk);
    bus.req_valid = '0;
    @(negedge pclk);
    repeat (14) @(negedge pclk);
    bus.pready = 1'b1;
    bus.apb_read_data_out = 8'h5A;
    @(negedge pclk);
    bus_idle();
    n_checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 8'h5A) begin n_fail++; $display("FAIL edge_completion_wins: got rsp_valid=%b err=%b rdata=%h expected 0001 0 5a", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    @(negedge pclk);
  endtask
  task automatic test_reset_mid_wait();
    @(negedge pclk);
    set_req(3, 1'b1, 9'h0F0, 8'h00);
    @(negedge pclk);
    n_checks++;
    if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL rst_ready3: got %b expected 1000", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge pclk);
    @(negedge pclk);
    n_checks++;
    if (bus.apb_read_paddr !== 9'h0F0) begin n_fail++; $display("FAIL rst_pre_wait: got raddr=%h expected 0f0", bus.apb_read_paddr); end
    presetn = 1'b0;
    #1;
    n_checks++;
    if (all_out() !== '0) begin n_fail++; $display("FAIL rst_async_clear: got %h expected 0", all_out()); end
    set_req(3, 1'b1, 9'h0F0, 8'h00);
    set_req(0, 1'b0, 9'h011, 8'h22);
    bus.psel = 1'b1;
    bus.penable = 1'b1;
    bus.pready = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_no_rsp: got %b expected 0000", bus.rsp_valid); end
    bus_idle();
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_first_grant: got ready=%b rsp_valid=%b expected 0001 0000", bus.req_ready, bus.rsp_valid); end
    bus.req_valid = '0;
    repeat (3) @(negedge pclk);
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_fairness();
    test_slave_error();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Round-robin arbiter that shares the single APB controller request port (transfer / read_write / write and read address / write data) between NUM_REQ requesters. It accepts one request at a time and drives the controller command. It monitors the APB bus for completion, then returns read data and error status to the owning requester. It sits between the bus-master agents and the APB controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 9, APB address width (matches `addr_width)
DATA_WIDTH, 8, APB data width (matches `data_width)
TIMEOUT, 15, max WAIT cycles before forced error completion

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request pending
req_rw  in  NUM_REQ  1=read, 0=write
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
req_ready  out  NUM_REQ  one-hot acceptance pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  error, valid with rsp_valid
transfer  out  1  command strobe to APB controller
read_write  out  1  command direction
apb_write_paddr  out  ADDR_WIDTH  write address
apb_read_paddr  out  ADDR_WIDTH  read address
apb_write_data  out  DATA_WIDTH  write data
apb_read_data_out  in  DATA_WIDTH  controller read data
pslverr  in  1  slave error
psel, penable, pready  in  1 each  observed APB bus signals; completion = psel & penable & pready

Behaviour:
- Clock and reset: one clock, pclk. presetn is asynchronous, active-low.
- Reset: all outputs 0, state IDLE, timeout counter 0, last_grant = NUM_REQ-1 so requester 0 has first priority.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Bus outputs are all 0.
  - If any req_valid: pick the winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Capture the winner's rw/addr/wdata and owner index.
  - Pulse req_ready[winner] for 1 cycle, then go to ISSUE.
  - If no req_valid: stay in IDLE.
- ISSUE:
  - transfer=1 for exactly this one cycle; read_write = captured rw.
  - Write: apb_write_paddr=addr, apb_write_data=wdata, apb_read_paddr=0.
  - Read: apb_read_paddr=addr, write address and write data = 0.
  - Go to WAIT.
- WAIT:
  - transfer=0; read_write, addresses and data are held stable.
  - Timeout counter increments each cycle.
  - On completion: capture pslverr, and apb_read_data_out for reads (0 for writes), then go to RESP.
  - If the counter reaches TIMEOUT without completion: err=1, rdata=0, go to RESP.
  - Completion in the same cycle as counter==TIMEOUT: completion wins.
- RESP:
  - rsp_valid[owner]=1 for 1 cycle, with rsp_rdata and rsp_err.
  - last_grant=owner; counter cleared.
  - Bus outputs return to 0; go to IDLE.
  - rsp_rdata/rsp_err are 0 outside RESP.
- Latency: req_ready to transfer = 1 cycle; completion to rsp_valid = 1 cycle; minimum request-to-request spacing = 4 cycles.
- Requester rules:
  - A requester holds req_valid and its fields until req_ready.
  - Fields may change after req_ready (they are captured).
  - Deasserting req_valid before grant is legal; the request is simply not served.
  - Requests arriving in ISSUE/WAIT/RESP wait for the next IDLE.
- Completion seen in IDLE/ISSUE/RESP is ignored.
- Reset mid-operation: the transaction is abandoned, no rsp_valid is issued, and priority restarts at requester 0.
- Single requester continuously valid: served back-to-back, each transaction 4+ cycles.

Decomposition:
- Package apb_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - timeout counter width $clog2(TIMEOUT+1)
  - owner index width $clog2(NUM_REQ)
- Widths come from defines.svh.
- Sub-module apb_rr_picker (combinational): inputs req vector and last_grant; outputs one-hot grant, index and any_valid.

Test Plan:
1. Write: req0 write, addr 9'h12A, data 8'h5C.
   -> req_ready[0] pulse, then a 1-cycle transfer with read_write=0, apb_write_paddr=12A, apb_write_data=5C, apb_read_paddr=0.
   -> After pready: rsp_valid[0]=1, rsp_err=0.
2. Read: req2 read, addr 9'h045; slave returns 8'hA7.
   -> apb_read_paddr=045 held stable through WAIT.
   -> rsp_valid[2]=1 with rsp_rdata=A7 one cycle after completion.
3. Fairness: all four requesters held valid continuously.
   -> grant order 0,1,2,3,0,1; no requester is granted twice before the others.
4. Slave error: pslverr=1 on the completion cycle of a req1 write.
   -> rsp_valid[1]=1, rsp_err=1, rsp_rdata=0.
5. Timeout: pready held 0.
   -> Exactly 15 cycles in WAIT, then rsp_valid with rsp_err=1, rsp_rdata=0; the arbiter returns to IDLE.
6. Reset mid-WAIT: presetn asserted during a req3 read.
   -> All outputs 0 asynchronously; no rsp_valid[3].
   -> After release, with requesters 0 and 3 pending, requester 0 is granted first.
